// File: rtl/morra_match_ctrl.sv
// rtl/morra_match_ctrl.sv - rock-paper-scissors match controller with lead/limit rules and match tallies
module morra_match_ctrl #(
    parameter int LIMIT_W    = 4,
    parameter int LIMIT_BASE = 4,
    parameter int LEAD_WIN   = 2,
    parameter int MIN_ROUNDS = 4,
    parameter int TALLY_W    = 4,
    parameter int CNT_W      = $clog2(2**LIMIT_W + LIMIT_BASE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LIMIT_W-1:0] cfg,
    input  logic [1:0]         move1,
    input  logic [1:0]         move2,
    output logic [1:0]         round_res,
    output logic [1:0]         match_res,
    output logic [CNT_W-1:0]   round_cnt,
    output logic [CNT_W-1:0]   score1,
    output logic [CNT_W-1:0]   score2,
    output logic [TALLY_W-1:0] tally1,
    output logic [TALLY_W-1:0] tally2,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   limit_q, limit_d;
    logic [CNT_W-1:0]   round_cnt_q, round_cnt_d;
    logic [CNT_W-1:0]   score1_q, score1_d;
    logic [CNT_W-1:0]   score2_q, score2_d;
    logic [TALLY_W-1:0] tally1_q, tally1_d;
    logic [TALLY_W-1:0] tally2_q, tally2_d;
    logic [1:0]         round_res_q, round_res_d;
    logic [1:0]         match_res_q, match_res_d;
    logic               restr_vld_q, restr_vld_d;
    logic               restr_p2_q, restr_p2_d;
    logic [1:0]         restr_mv_q, restr_mv_d;

    logic               round_valid;
    logic               p1_wins;
    logic               repeat_blocked;
    logic [CNT_W-1:0]   cnt_nx, s1_nx, s2_nx, lead_nx;
    logic [1:0]         end_res;

    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return (a == 2'b01 && b == 2'b11) || (a == 2'b11 && b == 2'b10) ||
               (a == 2'b10 && b == 2'b01);
    endfunction

    // The previous round's winner may not reuse its winning move.
    assign repeat_blocked = restr_vld_q &&
                            ((!restr_p2_q && move1 == restr_mv_q) ||
                             ( restr_p2_q && move2 == restr_mv_q));
    assign round_valid    = (move1 != 2'b00) && (move2 != 2'b00) && !repeat_blocked;
    assign p1_wins        = beats(move1, move2);

    always_comb begin
        state_d     = state_q;
        limit_d     = limit_q;
        round_cnt_d = round_cnt_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        tally1_d    = tally1_q;
        tally2_d    = tally2_q;
        round_res_d = 2'b00;
        match_res_d = match_res_q;
        restr_vld_d = restr_vld_q;
        restr_p2_d  = restr_p2_q;
        restr_mv_d  = restr_mv_q;
        cnt_nx      = round_cnt_q + CNT_W'(1);
        s1_nx       = score1_q;
        s2_nx       = score2_q;
        lead_nx     = '0;
        end_res     = 2'b00;

        if (start) begin
            state_d     = PLAY;
            limit_d     = CNT_W'(cfg) + CNT_W'(LIMIT_BASE);
            round_cnt_d = '0;
            score1_d    = '0;
            score2_d    = '0;
            match_res_d = 2'b00;
            restr_vld_d = 1'b0;
            restr_p2_d  = 1'b0;
            restr_mv_d  = 2'b00;
        end else if (state_q == PLAY && round_valid) begin
            if (move1 == move2) begin
                round_res_d = 2'b11;
                restr_vld_d = 1'b0;
            end else if (p1_wins) begin
                round_res_d = 2'b01;
                s1_nx       = score1_q + CNT_W'(1);
                restr_vld_d = 1'b1;
                restr_p2_d  = 1'b0;
                restr_mv_d  = move1;
            end else begin
                round_res_d = 2'b10;
                s2_nx       = score2_q + CNT_W'(1);
                restr_vld_d = 1'b1;
                restr_p2_d  = 1'b1;
                restr_mv_d  = move2;
            end
            round_cnt_d = cnt_nx;
            score1_d    = s1_nx;
            score2_d    = s2_nx;
            lead_nx     = (s1_nx >= s2_nx) ? (s1_nx - s2_nx) : (s2_nx - s1_nx);

            // Lead rule outranks the round limit; both look at post-update counters.
            if (cnt_nx >= CNT_W'(MIN_ROUNDS) && lead_nx >= CNT_W'(LEAD_WIN)) begin
                end_res = (s1_nx > s2_nx) ? 2'b01 : 2'b10;
            end else if (cnt_nx == limit_q) begin
                if (s1_nx > s2_nx)      end_res = 2'b01;
                else if (s2_nx > s1_nx) end_res = 2'b10;
                else                    end_res = 2'b11;
            end

            if (end_res != 2'b00) begin
                match_res_d = end_res;
                state_d     = DONE;
                if (end_res == 2'b01 && tally1_q != '1) tally1_d = tally1_q + TALLY_W'(1);
                if (end_res == 2'b10 && tally2_q != '1) tally2_d = tally2_q + TALLY_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            limit_q     <= '0;
            round_cnt_q <= '0;
            score1_q    <= '0;
            score2_q    <= '0;
            tally1_q    <= '0;
            tally2_q    <= '0;
            round_res_q <= 2'b00;
            match_res_q <= 2'b00;
            restr_vld_q <= 1'b0;
            restr_p2_q  <= 1'b0;
            restr_mv_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            limit_q     <= limit_d;
            round_cnt_q <= round_cnt_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            tally1_q    <= tally1_d;
            tally2_q    <= tally2_d;
            round_res_q <= round_res_d;
            match_res_q <= match_res_d;
            restr_vld_q <= restr_vld_d;
            restr_p2_q  <= restr_p2_d;
            restr_mv_q  <= restr_mv_d;
        end
    end

    assign round_res = round_res_q;
    assign match_res = match_res_q;
    assign round_cnt = round_cnt_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign tally1    = tally1_q;
    assign tally2    = tally2_q;
    assign busy      = (state_q == PLAY);

endmodule
